// File: rtl/bram_delay_pkg.sv
// -----------------------------------------------------------------------------
// bram_delay_pkg
// Shared definitions for the BRAM delay-line address sequencer:
//   state_t    - fill tracker state (FILL while the line refills, RUN when the
//                delayed stream is valid again)
//   min_delay  - smallest delay the BRAM read pipeline can realise
//   max_delay  - largest delay the circular buffer can realise
//   log2_ceil  - ceiling log2 helper for address-width derivations
// -----------------------------------------------------------------------------
package bram_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The read side needs at least one address of separation on top of the
  // BRAM/output-register latency, otherwise a read would hit the word being
  // written in the same cycle.
  function automatic int min_delay(input int latency);
    return latency + 1;
  endfunction

  // With 2^addr_width words the read pointer can trail the write pointer by
  // at most 2^addr_width-1 addresses; the read pipeline latency adds on top.
  function automatic int max_delay(input int latency, input int addr_width);
    return latency + (1 << addr_width) - 1;
  endfunction

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_delay_ptr.sv
// -----------------------------------------------------------------------------
// bram_delay_ptr
// Circular write pointer plus read-address subtractor for the delay-line BRAM.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   ce       in   clock enable; the write pointer advances only when ce=1
//   off      in   read offset behind the write pointer (delay - latency),
//                 already reduced modulo the BRAM depth
//   wr_addr  out  BRAM write address (free-running, wraps silently)
//   rd_addr  out  BRAM read address = wr_addr - off (mod depth)
// -----------------------------------------------------------------------------
module bram_delay_ptr #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] off,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  logic [ADDR_WIDTH-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (ce) begin
      // Natural overflow gives the modulo-depth wrap.
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  assign wr_addr = wr_ptr;

  // The read address is combinational so a new offset reaches the BRAM in the
  // cycle right after a reload. It is held at 0 while reset is asserted so the
  // BRAM port sees a quiet, known address during reset.
  assign rd_addr = rst_n ? (wr_ptr - off) : '0;

endmodule

// File: rtl/bram_delay_ctrl.sv
// -----------------------------------------------------------------------------
// bram_delay_ctrl
// Address sequencer and fill tracker for a runtime-programmable delay line
// built from a simple dual-port BRAM with registered read. The delay can be
// reloaded without a reset; dout_valid drops while the line refills with data
// written under the new delay and rises once that data reaches the output.
//
// Optional feature: define BRAM_DELAY_CTRL_ERR_EN to range-check delay_in on
// load. Out-of-range requests are clamped to the legal window and err is set
// until reset. Without the macro delay_in loads unmodified and err is 0.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   ce          in   clock enable; all state advances only when ce=1
//   delay_in    in   requested delay in ce cycles
//   delay_load  in   load delay_in (sampled when ce=1)
//   wr_en       out  BRAM write enable
//   wr_addr     out  BRAM write address
//   rd_en       out  BRAM read enable
//   rd_addr     out  BRAM read address
//   dout_valid  out  delayed output belongs to the current delay setting
//   busy        out  line is (re)filling after reset or reload
//   delay_cur   out  delay currently in effect
//   err         out  sticky range error
// -----------------------------------------------------------------------------
module bram_delay_ctrl
  import bram_delay_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2,
  parameter int DELAY      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [ADDR_WIDTH:0]   delay_in,
  input  logic                  delay_load,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  dout_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   delay_cur,
  output logic                  err
);

  localparam int DW = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0]   DELAY_RST = DW'(DELAY);
  localparam logic [ADDR_WIDTH-1:0] LAT_A     = ADDR_WIDTH'(LATENCY);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic [ADDR_WIDTH:0]   fill_nxt;
  logic [ADDR_WIDTH:0]   delay_q;
  logic [ADDR_WIDTH:0]   delay_nxt;
  logic [ADDR_WIDTH:0]   delay_sel;
  logic [ADDR_WIDTH-1:0] off;
  logic                  load_req;

  assign load_req = ce & delay_load;

  // ---------------------------------------------------------------------------
  // Delay selection (optional range check)
  // ---------------------------------------------------------------------------
`ifdef BRAM_DELAY_CTRL_ERR_EN
  localparam logic [ADDR_WIDTH:0] DLY_MIN = DW'(min_delay(LATENCY));
  localparam logic [ADDR_WIDTH:0] DLY_MAX = DW'(max_delay(LATENCY, ADDR_WIDTH));

  logic clamp;
  logic err_q;

  always_comb begin
    delay_sel = delay_in;
    clamp     = 1'b0;
    if (delay_in < DLY_MIN) begin
      delay_sel = DLY_MIN;
      clamp     = 1'b1;
    end else if (delay_in > DLY_MAX) begin
      delay_sel = DLY_MAX;
      clamp     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load_req && clamp) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Unchecked: an out-of-range delay still yields bounded addressing because
  // only the low ADDR_WIDTH bits of the offset reach the subtractor.
  assign delay_sel = delay_in;
  assign err       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Fill tracker: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    delay_nxt = delay_q;
    if (ce) begin
      if (delay_load) begin
        // Any load, even of the same value, restarts the fill so downstream
        // logic gets a deterministic resync point.
        delay_nxt = delay_sel;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else if (state == FILL) begin
        if (fill_cnt != delay_q) begin
          fill_nxt = fill_cnt + 1'b1;
        end
        // The transition edge is the delay_q-th ce edge after the fill began,
        // which is exactly when the first word written under this delay
        // appears at the read-pipeline output.
        if (fill_cnt == delay_q - 1'b1) begin
          state_nxt = RUN;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fill tracker: state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      delay_q  <= DELAY_RST;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      delay_q  <= delay_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  // The read pipeline supplies LATENCY clocks of the delay, so the read pointer
  // only trails the write pointer by delay - LATENCY. Subtracting in
  // ADDR_WIDTH bits equals the full-width difference reduced modulo depth.
  assign off = delay_q[ADDR_WIDTH-1:0] - LAT_A;

  bram_delay_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .off     (off),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr)
  );

  // Both ports run every enabled cycle; held low during reset.
  assign wr_en = ce & rst_n;
  assign rd_en = ce & rst_n;

  assign busy       = (state == FILL);
  assign dout_valid = (state == RUN);
  assign delay_cur  = delay_q;

endmodule
